// File: rtl/overlay_circles_pkg.sv
// Shared types for the circle-overlay sequencer: descriptor layout, field
// positions within the configuration word, and the walk FSM states.
package overlay_circles_pkg;

  localparam int X_LSB    = 0;
  localparam int X_W      = 11;
  localparam int Y_LSB    = 11;
  localparam int Y_W      = 11;
  localparam int R_LSB    = 22;
  localparam int R_W      = 8;
  localparam int RSVD_BIT = 30;
  localparam int EN_BIT   = 31;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    ISSUE,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic           en;
    logic           rsvd;
    logic [R_W-1:0] r;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } circle_desc_t;

  function automatic circle_desc_t unpack_desc(input logic [31:0] word);
    circle_desc_t d;
    d.x    = word[X_LSB +: X_W];
    d.y    = word[Y_LSB +: Y_W];
    d.r    = word[R_LSB +: R_W];
    d.rsvd = word[RSVD_BIT];
    d.en   = word[EN_BIT];
    return d;
  endfunction

endpackage

// File: rtl/overlay_circle_bank.sv
// Dual-bank circle descriptor table: writes land in the shadow bank (~sel),
// reads and the enable mask come from the active bank (sel).
module overlay_circle_bank
  import overlay_circles_pkg::*;
#(
  parameter int NUM_CIRCLES = 16,
  localparam int IDX_W = $clog2(NUM_CIRCLES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sel,
  input  logic                   we,
  input  logic [IDX_W-1:0]       waddr,
  input  circle_desc_t           wdesc,
  input  logic [IDX_W-1:0]       ridx,
  output circle_desc_t           rdesc,
  output logic [NUM_CIRCLES-1:0] active_mask,
  output logic [NUM_CIRCLES-1:0] shadow_mask
);

  circle_desc_t mem [2][NUM_CIRCLES];
  logic         shadow_sel;

  assign shadow_sel = ~sel;

  // NOTE: this table is small and every entry must come up disabled, so it is
  // built from flops with a full reset rather than an unresettable RAM.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_CIRCLES; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else if (we) begin
      mem[shadow_sel][waddr] <= wdesc;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CIRCLES; i++) begin
      active_mask[i] = mem[sel][i].en;
      shadow_mask[i] = mem[shadow_sel][i].en;
    end
  end

  assign rdesc = mem[sel][ridx];

endmodule

// File: rtl/overlay_circle_sequencer.sv
// Per-frame circle scheduler: on frame_start walks the active bank and hands
// each enabled descriptor to the draw engine over a valid/ready handshake.
module overlay_circle_sequencer
  import overlay_circles_pkg::*;
#(
  parameter int NUM_CIRCLES = 16,
  parameter int COORD_W     = 11,
  parameter int RAD_W       = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic                           cfg_we,
  input  logic [$clog2(NUM_CIRCLES)-1:0] cfg_addr,
  input  logic [31:0]                    cfg_wdata,
  input  logic                           cfg_commit,
  input  logic                           frame_start,
  output logic                           circ_valid,
  input  logic                           circ_ready,
  output logic [COORD_W-1:0]             circ_x,
  output logic [COORD_W-1:0]             circ_y,
  output logic [RAD_W-1:0]               circ_r,
  output logic                           circ_last,
  output logic                           busy,
  output logic                           commit_pending,
  output logic [7:0]                     overrun_cnt
);

  localparam int IDX_W = $clog2(NUM_CIRCLES);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_CIRCLES - 1);

  seq_state_t             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       last_idx_q, last_idx_d;
  logic                   any_en_q, any_en_d;
  logic                   active_sel_q, active_sel_d;
  logic                   commit_pending_q, commit_pending_d;
  logic [7:0]             overrun_q, overrun_d;
  logic [COORD_W-1:0]     x_q, x_d, y_q, y_d;
  logic [RAD_W-1:0]       r_q, r_d;
  logic                   last_q, last_d;

  circle_desc_t           rdesc;
  logic [NUM_CIRCLES-1:0] active_mask, shadow_mask, post_mask;
  logic [IDX_W-1:0]       enc_last;

  overlay_circle_bank #(
    .NUM_CIRCLES(NUM_CIRCLES)
  ) u_bank (
    .clk        (ACLK),
    .rst_n      (ARESETN),
    .sel        (active_sel_q),
    .we         (cfg_we),
    .waddr      (cfg_addr),
    .wdesc      (unpack_desc(cfg_wdata)),
    .ridx       (idx_q),
    .rdesc      (rdesc),
    .active_mask(active_mask),
    .shadow_mask(shadow_mask)
  );

  // Walk bounds are taken from the bank that will be active after any swap
  // happening on this frame_start.
  always_comb begin
    post_mask = commit_pending_q ? shadow_mask : active_mask;
    enc_last  = '0;
    for (int i = 0; i < NUM_CIRCLES; i++) begin
      if (post_mask[i]) enc_last = IDX_W'(i);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    last_idx_d       = last_idx_q;
    any_en_d         = any_en_q;
    active_sel_d     = active_sel_q;
    commit_pending_d = commit_pending_q;
    overrun_d        = overrun_q;
    x_d              = x_q;
    y_d              = y_q;
    r_d              = r_q;
    last_d           = last_q;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d    = SCAN;
          idx_d      = '0;
          last_idx_d = enc_last;
          any_en_d   = |post_mask;
          if (commit_pending_q) begin
            active_sel_d     = ~active_sel_q;
            commit_pending_d = 1'b0;
          end
        end
      end
      SCAN: begin
        if (!any_en_q) begin
          state_d = DONE;
        end else if (rdesc.en) begin
          state_d = ISSUE;
          x_d     = COORD_W'(rdesc.x);
          y_d     = COORD_W'(rdesc.y);
          r_d     = RAD_W'(rdesc.r);
          last_d  = (idx_q == last_idx_q);
        end else if (idx_q == IDX_MAX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ISSUE: begin
        if (circ_ready) begin
          if (last_q) begin
            state_d = DONE;
          end else begin
            state_d = SCAN;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A commit coinciding with a swap re-arms for the following frame.
    if (cfg_commit) commit_pending_d = 1'b1;

    if (frame_start && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      last_idx_q       <= '0;
      any_en_q         <= 1'b0;
      active_sel_q     <= 1'b0;
      commit_pending_q <= 1'b0;
      overrun_q        <= '0;
      x_q              <= '0;
      y_q              <= '0;
      r_q              <= '0;
      last_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      last_idx_q       <= last_idx_d;
      any_en_q         <= any_en_d;
      active_sel_q     <= active_sel_d;
      commit_pending_q <= commit_pending_d;
      overrun_q        <= overrun_d;
      x_q              <= x_d;
      y_q              <= y_d;
      r_q              <= r_d;
      last_q           <= last_d;
    end
  end

  assign circ_valid     = (state_q == ISSUE);
  assign circ_last      = last_q && circ_valid;
  assign circ_x         = x_q;
  assign circ_y         = y_q;
  assign circ_r         = r_q;
  assign busy           = (state_q != IDLE);
  assign commit_pending = commit_pending_q;
  assign overrun_cnt    = overrun_q;

endmodule

// File: tb/tb_overlay_circle_sequencer.sv
// Directed bench for overlay_circle_sequencer: bank swap, walk timing,
// back-pressure, overrun counting and reset mid-walk.
module tb_overlay_circle_sequencer;

  localparam int NUM_CIRCLES = 16;
  localparam int COORD_W     = 11;
  localparam int RAD_W       = 8;

  logic               ACLK;
  logic               ARESETN;
  logic               cfg_we;
  logic [3:0]         cfg_addr;
  logic [31:0]        cfg_wdata;
  logic               cfg_commit;
  logic               frame_start;
  logic               circ_valid;
  logic               circ_ready;
  logic [COORD_W-1:0] circ_x;
  logic [COORD_W-1:0] circ_y;
  logic [RAD_W-1:0]   circ_r;
  logic               circ_last;
  logic               busy;
  logic               commit_pending;
  logic [7:0]         overrun_cnt;

  typedef struct {
    int x;
    int y;
    int r;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  overlay_circle_sequencer #(
    .NUM_CIRCLES(NUM_CIRCLES),
    .COORD_W    (COORD_W),
    .RAD_W      (RAD_W)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_commit    (cfg_commit),
    .frame_start   (frame_start),
    .circ_valid    (circ_valid),
    .circ_ready    (circ_ready),
    .circ_x        (circ_x),
    .circ_y        (circ_y),
    .circ_r        (circ_r),
    .circ_last     (circ_last),
    .busy          (busy),
    .commit_pending(commit_pending),
    .overrun_cnt   (overrun_cnt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int x, input int y, input int r, input bit last);
    exp_t e;
    e.x = x; e.y = y; e.r = r; e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic write_entry(input int idx, input int x, input int y, input int r,
                             input bit en, input bit rsvd);
    logic [31:0] w;
    w = {en, rsvd, r[7:0], y[10:0], x[10:0]};
    cfg_we    = 1'b1;
    cfg_addr  = idx[3:0];
    cfg_wdata = w;
    @(negedge ACLK);
    cfg_we    = 1'b0;
  endtask

  task automatic pulse_commit();
    cfg_commit = 1'b1;
    @(negedge ACLK);
    cfg_commit = 1'b0;
  endtask

  // Accepts descriptors with ready high until busy drops; cyc 1 is the
  // first negedge after a frame_start pulse.
  task automatic drain(input string tag, input int n_exp, output int first_lat,
                       output int busy_cyc);
    int   cyc;
    int   seen;
    exp_t e;
    cyc = 1; seen = 0; first_lat = -1; busy_cyc = 0;
    circ_ready = 1'b1;
    while (busy && cyc < 400) begin
      if (circ_valid) begin
        if (first_lat < 0) first_lat = cyc;
        seen++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check({tag, "_x"}, circ_x, e.x);
          check({tag, "_y"}, circ_y, e.y);
          check({tag, "_r"}, circ_r, e.r);
          check({tag, "_last"}, circ_last, e.last);
        end
      end
      busy_cyc++;
      @(negedge ACLK);
      cyc++;
    end
    check({tag, "_ended"}, busy, 0);
    check({tag, "_count"}, seen, n_exp);
    exp_q.delete();
  endtask

  task automatic run_frame(input string tag, input bit with_commit, input int n_exp,
                           input int exp_lat, input int exp_busy);
    int lat;
    int bc;
    circ_ready  = 1'b1;
    frame_start = 1'b1;
    cfg_commit  = with_commit;
    @(negedge ACLK);
    frame_start = 1'b0;
    cfg_commit  = 1'b0;
    check({tag, "_busy_start"}, busy, 1);
    drain(tag, n_exp, lat, bc);
    if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
    if (exp_busy >= 0) check({tag, "_busy_cycles"}, bc, exp_busy);
  endtask

  // Starts a frame with ready low and stops at the first presented descriptor.
  task automatic start_stalled(input string tag, output int lat);
    int cyc;
    circ_ready  = 1'b0;
    frame_start = 1'b1;
    @(negedge ACLK);
    frame_start = 1'b0;
    cyc = 1;
    while (!circ_valid && cyc < 50) begin
      @(negedge ACLK);
      cyc++;
    end
    check({tag, "_valid_seen"}, circ_valid, 1);
    lat = cyc;
  endtask

  initial begin
    int lat;
    int bc;
    ARESETN     = 1'b0;
    cfg_we      = 1'b0;
    cfg_addr    = '0;
    cfg_wdata   = '0;
    cfg_commit  = 1'b0;
    frame_start = 1'b0;
    circ_ready  = 1'b0;
    repeat (3) @(negedge ACLK);

    check("reset_valid", circ_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_pending", commit_pending, 0);
    check("reset_overrun", overrun_cnt, 0);
    check("reset_desc", {circ_x, circ_y, circ_r, circ_last}, 0);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Two enabled entries with a gap between them.
    write_entry(0, 100, 50, 20, 1'b1, 1'b0);
    write_entry(3, 640, 360, 8, 1'b1, 1'b0);
    pulse_commit();
    check("t1_pending_set", commit_pending, 1);
    push_exp(100, 50, 20, 1'b0);
    push_exp(640, 360, 8, 1'b1);
    run_frame("t1", 1'b0, 2, 2, 7);
    check("t1_pending_clr", commit_pending, 0);

    // Swap to the still-empty bank: nothing issued, SCAN then DONE.
    pulse_commit();
    run_frame("t2", 1'b0, 0, -1, 2);

    // Back-pressure on the first descriptor.
    write_entry(5, 7, 9, 3, 1'b1, 1'b0);
    pulse_commit();
    start_stalled("t3", lat);
    check("t3_latency", lat, 2);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_valid", circ_valid, 1);
      check("t3_hold_desc", {circ_x, circ_y, circ_r, circ_last},
            {11'd100, 11'd50, 8'd20, 1'b0});
      @(negedge ACLK);
    end
    circ_ready = 1'b1;
    @(negedge ACLK);
    check("t3_accepted_once", circ_valid, 0);
    push_exp(640, 360, 8, 1'b0);
    push_exp(7, 9, 3, 1'b1);
    drain("t3_rest", 2, lat, bc);

    // Shadow write without commit, then commit coinciding with frame_start.
    write_entry(2, 1500, 1023, 255, 1'b1, 1'b1);
    check("t4_no_pending", commit_pending, 0);
    push_exp(100, 50, 20, 1'b0);
    push_exp(640, 360, 8, 1'b0);
    push_exp(7, 9, 3, 1'b1);
    run_frame("t4a", 1'b0, 3, 2, 10);
    push_exp(100, 50, 20, 1'b0);
    push_exp(640, 360, 8, 1'b0);
    push_exp(7, 9, 3, 1'b1);
    run_frame("t4b", 1'b1, 3, 2, 10);
    check("t4b_pending", commit_pending, 1);
    push_exp(1500, 1023, 255, 1'b1);
    run_frame("t4c", 1'b0, 1, 4, 5);
    check("t4c_pending_clr", commit_pending, 0);

    // Overruns during a stalled walk; commit_pending must not be disturbed.
    start_stalled("t5", lat);
    check("t5_latency", lat, 4);
    pulse_commit();
    for (int i = 0; i < 3; i++) begin
      frame_start = 1'b1;
      @(negedge ACLK);
      frame_start = 1'b0;
      @(negedge ACLK);
    end
    check("t5_overrun3", overrun_cnt, 3);
    check("t5_pending_kept", commit_pending, 1);
    check("t5_still_valid", circ_valid, 1);
    push_exp(1500, 1023, 255, 1'b1);
    drain("t5", 1, lat, bc);

    start_stalled("t5b", lat);
    check("t5b_pending_clr", commit_pending, 0);
    frame_start = 1'b1;
    repeat (100) @(negedge ACLK);
    check("t5b_overrun103", overrun_cnt, 103);
    repeat (200) @(negedge ACLK);
    frame_start = 1'b0;
    check("t5b_overrun_sat", overrun_cnt, 255);
    push_exp(100, 50, 20, 1'b0);
    push_exp(640, 360, 8, 1'b0);
    push_exp(7, 9, 3, 1'b1);
    drain("t5b", 3, lat, bc);
    check("t5b_overrun_hold", overrun_cnt, 255);

    // Reset while a descriptor is presented.
    start_stalled("t6", lat);
    #2;
    ARESETN = 1'b0;
    #1;
    check("t6_valid_drop", circ_valid, 0);
    check("t6_busy_drop", busy, 0);
    check("t6_overrun_clr", overrun_cnt, 0);
    check("t6_desc_clr", {circ_x, circ_y, circ_r}, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    run_frame("t6a", 1'b0, 0, -1, 2);
    pulse_commit();
    run_frame("t6b", 1'b0, 0, -1, 2);
    check("t6b_pending_clr", commit_pending, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/overlay_circle_sequencer.md
Name: overlay_circle_sequencer

Overview:
- Per-frame scheduler for the circle-overlay datapath.
- Holds a double-buffered table of up to NUM_CIRCLES circle descriptors, written by the AXI4-Lite register block.
- On each frame start it walks the active table and issues enabled circles one at a time to the draw engine over a valid/ready handshake.
- Table updates are tear-free: they take effect only at a frame boundary after an explicit commit.

Parameters:
- NUM_CIRCLES, 16, table depth (power of two, 2..64)
- COORD_W, 11, x/y coordinate width
- RAD_W, 8, radius width

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset, asynchronous, active-low
- cfg_we  in  1  write strobe, shadow table
- cfg_addr  in  $clog2(NUM_CIRCLES)  shadow entry index
- cfg_wdata  in  32  entry word: [10:0] x, [21:11] y, [29:22] radius, [30] reserved, [31] enable
- cfg_commit  in  1  one-cycle pulse; request bank swap at next frame_start
- frame_start  in  1  one-cycle pulse at vsync
- circ_valid  out  1  descriptor valid
- circ_ready  in  1  draw engine accepts
- circ_x  out  COORD_W  centre x
- circ_y  out  COORD_W  centre y
- circ_r  out  RAD_W  radius
- circ_last  out  1  final enabled descriptor of this frame
- busy  out  1  walk in progress
- commit_pending  out  1  swap armed
- overrun_cnt  out  8  frame_start pulses dropped while busy, saturating

Behaviour:
- Reset (async assert, sync deassert by upstream):
  - All outputs 0.
  - Both banks cleared (all entries disabled).
  - active_sel=0; FSM in IDLE.
  - Reset mid-walk drops circ_valid immediately, with no further descriptors.
- Banks:
  - cfg_we always writes bank ~active_sel.
  - Writes during a walk never affect the active bank.
  - The draw engine reads only the active bank.
- Swap:
  - cfg_commit sets commit_pending.
  - frame_start in IDLE with commit_pending=1 toggles active_sel and clears commit_pending.
  - cfg_commit in the same cycle as frame_start arms the swap for the next frame only.
  - After a swap the new shadow bank holds the previous active contents; software rewrites what it needs.
- FSM states: IDLE, SCAN, ISSUE, DONE.
  - IDLE: frame_start -> SCAN with idx=0. Latch last_idx = highest enabled index of the (post-swap) active bank and any_en = OR of enables. busy=1 from the next cycle.
  - SCAN, one cycle per entry:
    - If any_en=0 -> DONE.
    - If the entry is enabled -> ISSUE and register the descriptor (circ_valid=1 next cycle).
    - Otherwise, if idx=NUM_CIRCLES-1 -> DONE; else idx+1, stay in SCAN.
  - ISSUE: circ_x/y/r stable while circ_valid=1 and circ_ready=0. circ_last=1 iff idx==last_idx. On valid&&ready: if circ_last -> DONE, else idx+1 -> SCAN.
  - DONE: busy=0 next cycle -> IDLE.
- Latency:
  - frame_start at cycle 0 with entry 0 enabled gives circ_valid at cycle 2.
  - Each disabled entry adds 1 cycle.
  - Back-to-back enabled entries with circ_ready held high give one descriptor every 2 cycles.
- Overrun: frame_start while busy (SCAN/ISSUE/DONE) is ignored. overrun_cnt increments, saturating at 255. commit_pending is unchanged.
- cfg_addr >= NUM_CIRCLES cannot occur (the width matches the depth). Reserved bit 30 is stored but ignored.

Decomposition:
- Package overlay_circles_pkg holds:
  - circle_desc_t struct (en, r, y, x)
  - field position/width localparams matching the cfg_wdata layout
  - seq_state_t enum
- Sub-module overlay_circle_bank: dual-bank register file with write port to ~sel and read port from sel at index idx. It also exposes the enable mask of the active bank for the last_idx/any_en priority encoder.

Test Plan:
- Write entries 0 (x=100,y=50,r=20,en) and 3 (x=640,y=360,r=8,en), commit, then frame_start.
  - Expect exactly 2 descriptors: (100,50,20,last=0) then (640,360,8,last=1).
  - First circ_valid 2 cycles after frame_start; busy low after DONE.
- All entries disabled, frame_start -> no circ_valid; busy high for 1+1 cycles (SCAN, DONE) then low.
- Hold circ_ready=0 for 10 cycles on the first descriptor -> circ_valid and fields stable for all 10 cycles, accepted exactly once.
- Write new shadow data without commit, then frame_start -> old table issued. Commit and frame_start in the same cycle -> old table issued again. Next frame_start -> new table issued; commit_pending cleared.
- Send 3 frame_start pulses during a long walk (circ_ready=0) -> overrun_cnt=3 and the walk completes normally. Drive 300 overruns -> overrun_cnt holds at 255.
- Assert ARESETN=0 while circ_valid=1 -> circ_valid=0 immediately. After release, frame_start issues no descriptors (banks cleared).
